// File: rtl/wb_stage.sv
// rtl/wb_stage.sv - registered, handshaked RV32I/RV64I write-back stage
module wb_stage #(
  parameter int XLEN  = 32,
  parameter int RA_W  = 5,
  parameter int CNT_W = 64
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       in_sel,
  input  logic [2:0]       in_funct3,
  input  logic [RA_W-1:0]  in_rd,
  input  logic [XLEN-1:0]  in_alu,
  input  logic [XLEN-1:0]  in_pc,
  input  logic [XLEN-1:0]  in_imm,
  input  logic             mem_rvalid,
  input  logic [XLEN-1:0]  mem_rdata,
  output logic             wb_en,
  output logic [RA_W-1:0]  wb_rd,
  output logic [XLEN-1:0]  wb_data,
  output logic             wb_err,
  output logic [CNT_W-1:0] instret
);

  // Byte-lane offset width inside one XLEN word
  localparam int OFF_W = (XLEN == 64) ? 3 : 2;

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_WAIT = 1'b1;

  logic [0:0]       r_state;
  logic [RA_W-1:0]  r_rd;
  logic [2:0]       r_funct3;
  logic [OFF_W-1:0] r_off;
  logic             r_err;
  logic             r_wb_en;
  logic             r_wb_err;
  logic [RA_W-1:0]  r_wb_rd;
  logic [XLEN-1:0]  r_wb_data;
  logic [CNT_W-1:0] r_instret;

  logic             w_accept;
  logic             w_is_load;
  logic             w_load_done;
  logic             w_load_ok;
  logic [OFF_W-1:0] w_off;
  logic             w_err;
  logic [XLEN-1:0]  w_src;
  logic [XLEN-1:0]  w_field;
  logic [XLEN-1:0]  w_fmt;

  assign in_ready    = (r_state == S_IDLE);
  assign w_accept    = in_valid & in_ready;
  assign w_is_load   = (in_sel == 2'b01);
  assign w_off       = in_alu[OFF_W-1:0];
  assign w_load_done = (r_state == S_WAIT) & mem_rvalid;
  assign w_load_ok   = ~r_err & (r_rd != '0);
  assign w_field     = mem_rdata >> {r_off, 3'b000};

  // Legality and alignment of a load, judged from the accepting instruction
  always_comb begin
    w_err = 1'b0;
    case (in_funct3)
      3'b000, 3'b100: w_err = 1'b0;
      3'b001, 3'b101: w_err = w_off[0];
      3'b010:         w_err = |w_off[1:0];
      3'b110:         w_err = (XLEN != 64) | (|w_off[1:0]);
      3'b011:         w_err = (XLEN != 64) | (|w_off);
      default:        w_err = 1'b1;
    endcase
  end

  // Non-load source select; link address wraps naturally at XLEN bits
  always_comb begin
    w_src = in_alu;
    case (in_sel)
      2'b10:   w_src = in_pc + XLEN'(4);
      2'b11:   w_src = in_imm;
      default: w_src = in_alu;
    endcase
  end

  // Extend the shifted memory field according to the captured load format
  always_comb begin
    w_fmt = w_field;
    case (r_funct3)
      3'b000: begin
        w_fmt       = {XLEN{w_field[7]}};
        w_fmt[7:0]  = w_field[7:0];
      end
      3'b001: begin
        w_fmt       = {XLEN{w_field[15]}};
        w_fmt[15:0] = w_field[15:0];
      end
      3'b010: begin
        w_fmt       = {XLEN{w_field[31]}};
        w_fmt[31:0] = w_field[31:0];
      end
      3'b100: w_fmt = {{(XLEN-8){1'b0}}, w_field[7:0]};
      3'b101: w_fmt = {{(XLEN-16){1'b0}}, w_field[15:0]};
      3'b110: begin
        w_fmt       = '0;
        w_fmt[31:0] = w_field[31:0];
      end
      default: w_fmt = w_field;
    endcase
  end

  // FSM and capture of load context at accept
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_rd     <= '0;
      r_funct3 <= '0;
      r_off    <= '0;
      r_err    <= 1'b0;
    end else begin
      if (w_accept && w_is_load) begin
        r_state  <= S_WAIT;
        r_rd     <= in_rd;
        r_funct3 <= in_funct3;
        r_off    <= w_off;
        r_err    <= w_err;
      end else if (w_load_done) begin
        r_state  <= S_IDLE;
      end
    end
  end

  // Registered write port, error pulse and retired-instruction counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wb_en   <= 1'b0;
      r_wb_err  <= 1'b0;
      r_wb_rd   <= '0;
      r_wb_data <= '0;
      r_instret <= '0;
    end else begin
      r_wb_en  <= 1'b0;
      r_wb_err <= 1'b0;
      if (w_accept && !w_is_load) begin
        r_wb_en   <= (in_rd != '0);
        r_wb_rd   <= in_rd;
        r_wb_data <= (in_rd != '0) ? w_src : '0;
        r_instret <= r_instret + CNT_W'(1);
      end else if (w_load_done) begin
        r_wb_en   <= w_load_ok;
        r_wb_err  <= r_err;
        r_wb_rd   <= r_rd;
        r_wb_data <= w_load_ok ? w_fmt : '0;
        r_instret <= r_instret + CNT_W'(1);
      end
    end
  end

  assign wb_en   = r_wb_en;
  assign wb_err  = r_wb_err;
  assign wb_rd   = r_wb_rd;
  assign wb_data = r_wb_data;
  assign instret = r_instret;

endmodule
